// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolver sequencer.
//   state_t  - sequencer FSM encoding (also exposed on the debug state port)
//   idx_bw() - bit width needed to index n items (minimum 1)
//   KK, W_IDX_BW, ROW_BW, COL_BW - widths for the default 5x5 / 28x28 job
package conv_pkg;

  localparam int STATE_BW = 2;

  typedef enum logic [STATE_BW-1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int idx_bw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int K_DEFAULT = 5;
  localparam int W_DEFAULT = 28;
  localparam int H_DEFAULT = 28;

  localparam int KK       = K_DEFAULT * K_DEFAULT;
  localparam int W_IDX_BW = idx_bw(KK);
  localparam int ROW_BW   = idx_bw(H_DEFAULT);
  localparam int COL_BW   = idx_bw(W_DEFAULT);

endpackage

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if: control bundle between the stream source / datapath
// and the sequencer.
//   start, abort, weight_valid, pixel_valid : source -> sequencer
//   load_weight, weight_idx, en, out_valid,
//   row, col, busy, done, state             : sequencer -> datapath/observers
// Handshake: a weight is accepted in a cycle where load_weight is high, a
// pixel in a cycle where en is high; both are combinational copies of the
// matching *_valid in the state that consumes it, and there is no
// back-pressure (the sequencer is always ready in that state).
interface conv_sequencer_if #(
  parameter int KERNEL_SIZE = 5,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
);
  import conv_pkg::*;

  localparam int W_IDX_W = idx_bw(KERNEL_SIZE * KERNEL_SIZE);
  localparam int ROW_W   = idx_bw(IMG_HEIGHT);
  localparam int COL_W   = idx_bw(IMG_WIDTH);

  logic               start;
  logic               abort;
  logic               weight_valid;
  logic               pixel_valid;
  logic               load_weight;
  logic [W_IDX_W-1:0] weight_idx;
  logic               en;
  logic               out_valid;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic               busy;
  logic               done;
  state_t             state;

  modport master (
    output start, abort, weight_valid, pixel_valid,
    input  load_weight, weight_idx, en, out_valid, row, col, busy, done, state
  );

  modport slave (
    input  start, abort, weight_valid, pixel_valid,
    output load_weight, weight_idx, en, out_valid, row, col, busy, done, state
  );

endinterface

// File: rtl/conv_sequencer_scan_counter.sv
// scan_counter: raster-scan row/column counter.
//   clk, reset : clock, async active-high reset
//   inc        : advance one position (col first, wrapping into row)
//   clear      : return to (0,0); wins over inc
//   row, col   : current position
//   last       : position is (IMG_HEIGHT-1, IMG_WIDTH-1)
// Stepping from the last position wraps to (0,0).
module scan_counter
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  localparam int ROW_W = idx_bw(IMG_HEIGHT),
  localparam int COL_W = idx_bw(IMG_WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign last = (row == ROW_LAST) && (col == COL_LAST);

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: two-phase job control for the convolver datapath.
// Loads KERNEL_SIZE^2 weights, then streams an IMG_WIDTH x IMG_HEIGHT frame,
// flagging (one cycle late) every accepted pixel whose KxK window is fully
// inside the image.
//   clk, reset : clock, async active-high reset
//   bus        : conv_sequencer_if slave (requests in, enables/status out,
//                plus the FSM state for observation)
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 5,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic           clk,
  input  logic           reset,
  conv_sequencer_if.slave bus
);

  localparam int W_IDX_W = idx_bw(KERNEL_SIZE * KERNEL_SIZE);
  localparam int ROW_W   = idx_bw(IMG_HEIGHT);
  localparam int COL_W   = idx_bw(IMG_WIDTH);

  localparam logic [W_IDX_W-1:0] W_IDX_LAST = W_IDX_W'(KERNEL_SIZE * KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0]   ROW_FIRST  = ROW_W'(KERNEL_SIZE - 1);
  localparam logic [COL_W-1:0]   COL_FIRST  = COL_W'(KERNEL_SIZE - 1);

  state_t             state_q, state_d;
  logic [W_IDX_W-1:0] widx_q;
  logic               widx_inc, widx_clr;
  logic               cnt_inc, cnt_clr;
  logic               ov_q, ov_d;
  logic               load_weight, en;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic               last;

  scan_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clear (cnt_clr),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      widx_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      if (widx_clr)      widx_q <= '0;
      else if (widx_inc) widx_q <= widx_q + W_IDX_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    load_weight = 1'b0;
    en          = 1'b0;
    widx_inc    = 1'b0;
    widx_clr    = 1'b0;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    ov_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = LOAD_W;
          widx_clr = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      LOAD_W: begin
        load_weight = bus.weight_valid;
        if (bus.weight_valid) begin
          if (widx_q == W_IDX_LAST) begin
            state_d  = STREAM;
            widx_clr = 1'b1;
            cnt_clr  = 1'b1;
          end else begin
            widx_inc = 1'b1;
          end
        end
      end
      STREAM: begin
        en = bus.pixel_valid;
        if (bus.pixel_valid) begin
          cnt_inc = 1'b1;
          // Window is complete once the pixel at (row,col) is the bottom-right
          // corner of a KxK block that lies inside the frame.
          ov_d = (row >= ROW_FIRST) && (col >= COL_FIRST);
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Cancel overrides everything decided above in the same cycle.
    if (bus.abort) begin
      state_d     = IDLE;
      load_weight = 1'b0;
      en          = 1'b0;
      widx_inc    = 1'b0;
      widx_clr    = 1'b1;
      cnt_inc     = 1'b0;
      cnt_clr     = 1'b1;
      ov_d        = 1'b0;
    end
  end

  assign bus.load_weight = load_weight;
  assign bus.weight_idx  = widx_q;
  assign bus.en          = en;
  assign bus.out_valid   = ov_q;
  assign bus.row         = row;
  assign bus.col         = col;
  assign bus.busy        = (state_q == LOAD_W) || (state_q == STREAM);
  assign bus.done        = (state_q == DONE);
  assign bus.state       = state_q;

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
Top-level sequencer for the convolver datapath. It runs a two-phase job: it loads KERNEL_SIZE×KERNEL_SIZE weights into the weight shift chain, then streams an IMG_WIDTH×IMG_HEIGHT frame through the line/window shift registers. It tracks the scan position and flags every cycle whose window lies fully inside the image. It sits between the input stream source and the convolver datapath, and drives all of the datapath's shift and write enables.

Parameters:
KERNEL_SIZE, 5, kernel edge length K (window is K×K)
IMG_WIDTH, 28, pixels per row W
IMG_HEIGHT, 28, rows per frame H

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high; forces IDLE and clears all state
start  input  1  job request; sampled only in IDLE
abort  input  1  synchronous cancel; valid in any state
weight_valid  input  1  a weight word is present on the datapath input this cycle
pixel_valid  input  1  a pixel word is present on the datapath input this cycle
load_weight  output  1  write/shift enable for the weight chain
weight_idx  output  $clog2(K*K)  index of the weight being written
en  output  1  shift enable for the pixel window/line buffers
out_valid  output  1  datapath convolution result is valid this cycle
row  output  $clog2(IMG_HEIGHT)  row of the next pixel to be accepted
col  output  $clog2(IMG_WIDTH)  column of the next pixel to be accepted
busy  output  1  high in LOAD_W and STREAM
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- States: IDLE, LOAD_W, STREAM, DONE. Encoding is shared with the package.
- On reset assertion: state=IDLE. weight_idx, row, col=0. out_valid, done=0. load_weight, en, busy=0.
- IDLE:
  - start=1 → LOAD_W next cycle; weight counter cleared.
  - weight_valid and pixel_valid are ignored.
- LOAD_W:
  - load_weight = weight_valid (combinational, same cycle).
  - weight_idx = current counter; counter increments on each accepted weight.
  - Accepting weight index K*K-1 → STREAM next cycle, with row=col=0.
  - Gaps in weight_valid stall the counter.
- STREAM:
  - en = pixel_valid (combinational); pixel_valid is ignored in all other states.
  - On each accepted pixel, col increments. At col=W-1 it wraps to 0 and row increments.
  - out_valid is registered. It is high the cycle after a pixel is accepted at (row≥K-1 AND col≥K-1), evaluated with pre-increment row/col; otherwise it is low.
  - Accepting pixel (H-1, W-1) → DONE next cycle. out_valid for that pixel is high in the DONE cycle.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - row/col hold their final wrapped value (0, 0).
- abort=1 → IDLE next cycle from any state. Counters clear and done is not pulsed. abort wins over start, weight_valid and pixel_valid in the same cycle; en and load_weight are forced 0 that cycle.
- start outside IDLE is ignored (no queueing).
- out_valid count per frame: (W-K+1)·(H-K+1). For the defaults that is 24·24 = 576, over 784 accepted pixels.
- Counters never exceed their terminal value. Terminal compares use the parameters, not the counter width.
- Asynchronous reset mid-operation behaves identically to power-on reset. No partial state survives.

Decomposition:
- Package conv_pkg holds:
  - the state typedef/localparams (STATE_BW=2, IDLE, LOAD_W, STREAM, DONE);
  - the width functions/localparams for KK = K*K, W_IDX_BW, ROW_BW, COL_BW.
- One sub-module is natural: scan_counter. It is a parameterised row/column wrap counter with inc/clear inputs, and outputs row, col and last (row==H-1 AND col==W-1). It is reused by the future stride/padding variants.
- Everything else stays in conv_sequencer.

Test Plan:
- Reset check: assert reset asynchronously between clock edges → all outputs 0 immediately. Release, idle 5 cycles → state remains IDLE with busy=0.
- Weight load: start, then 25 weight_valid pulses with random 0–3 cycle gaps → load_weight matches weight_valid, weight_idx steps 0..24. STREAM is entered the cycle after idx 24 is accepted; no en occurs during LOAD_W.
- Full frame, continuous: 784 back-to-back pixel_valid → first out_valid the cycle after pixel #116 (row 4, col 4), 576 out_valid total, done pulses once, then IDLE.
- Full frame with pixel_valid toggling 50% → en tracks pixel_valid exactly. Same 576 out_valid; none occurs after a pixel with col<4 or row<4.
- abort at pixel #300 plus start pulses during busy → IDLE next cycle, no done, row=col=0. Extra starts have no effect; a subsequent fresh start restarts from LOAD_W.
- Async reset mid-STREAM (row 10) → immediate IDLE/zeroed outputs. A following full job completes normally with 576 outputs.
